// File: rtl/vedic_mac_accumulator.sv
// Streaming 8x8 unsigned multiply-accumulate (dot product) built around a Vedic
// (Urdhva Tiryagbhyam) multiplier, with a 3-stage pipeline and a held output register.
module eight_bit_vedic_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // 2x2 crosswise/vertical cell: the leaf of the Vedic tree.
  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] t;
    logic [1:0] u;
    t = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
    u = {1'b0, x[1] & y[1]} + {1'b0, t[1]};
    return {u, t[0], x[0] & y[0]};
  endfunction

  function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0 = vedic2(x[1:0], y[1:0]);
    q1 = vedic2(x[3:2], y[1:0]);
    q2 = vedic2(x[1:0], y[3:2]);
    q3 = vedic2(x[3:2], y[3:2]);
    return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
  endfunction

  logic [7:0] q0, q1, q2, q3;

  always_comb begin
    q0 = vedic4(a[3:0], b[3:0]);
    q1 = vedic4(a[7:4], b[3:0]);
    q2 = vedic4(a[3:0], b[7:4]);
    q3 = vedic4(a[7:4], b[7:4]);
    p  = {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
  end

endmodule

module vedic_mac_accumulator #(
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in1,
  input  logic [7:0]       in2,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_cnt,
  output logic             out_ovf
);

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, next_state;

  logic              a_vld, a_last;
  logic [OP_W-1:0]   a_in1, a_in2;
  logic [PROD_W-1:0] prod;
  logic              b_vld, b_last;
  logic [PROD_W-1:0] b_prod;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;

  logic              en;
  logic              fin;
  logic              step;
  logic [ACC_W:0]    sum;
  logic [CNT_W-1:0]  cnt_inc;

  eight_bit_vedic_multiplier u_mul (
    .a (a_in1),
    .b (a_in2),
    .p (prod)
  );

  // The whole pipe stalls only when a finished result would overwrite an unread one.
  assign out_valid = (state == FULL);
  assign en        = !(out_valid && !out_ready && b_vld && b_last);
  assign in_ready  = en && !rst;
  assign fin       = b_vld && b_last && en;
  assign step      = b_vld && !b_last && en;
  assign sum       = {1'b0, acc} + (ACC_W+1)'(b_prod);
  assign cnt_inc   = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld  <= 1'b0;
      a_last <= 1'b0;
      a_in1  <= '0;
      a_in2  <= '0;
      b_vld  <= 1'b0;
      b_last <= 1'b0;
      b_prod <= '0;
    end else if (en) begin
      a_vld  <= in_valid;
      a_last <= in_last;
      a_in1  <= in1;
      a_in2  <= in2;
      b_vld  <= a_vld;
      b_last <= a_last;
      b_prod <= prod;
    end
  end

  // Running accumulator; cleared on the same edge that finalises a vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (fin) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (step) begin
      acc <= sum[ACC_W-1:0];
      cnt <= cnt_inc;
      ovf <= ovf | sum[ACC_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out     <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else if (fin) begin
      out     <= sum[ACC_W-1:0];
      out_cnt <= cnt_inc;
      out_ovf <= ovf | sum[ACC_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY:   if (fin) next_state = FULL;
      FULL:    if (fin) next_state = FULL;
               else if (out_ready) next_state = EMPTY;
      default: next_state = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// Directed and scoreboard checks for vedic_mac_accumulator at ACC_W=24 and ACC_W=16.
module tb_vedic_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in1 = '0;
  logic [7:0]  in2 = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, in_ready16;
  logic [23:0] out;
  logic [15:0] out16;
  logic        out_valid, out_valid16;
  logic [7:0]  out_cnt, out_cnt16;
  logic        out_ovf, out_ovf16;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [23:0] o24;
    logic        ovf24;
    logic [15:0] o16;
    logic        ovf16;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  bit   drv_done = 0;
  bit   mon_done = 0;

  vedic_mac_accumulator #(.ACC_W(24)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  vedic_mac_accumulator #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready16), .out(out16), .out_valid(out_valid16), .out_ready(out_ready),
    .out_cnt(out_cnt16), .out_ovf(out_ovf16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold one element until it is accepted; returns at acceptance edge + 1.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    bit acc = 0;
    in1 = a; in2 = b; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 2000 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    reset_dut();
    tick();
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out", out, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Single max element, latency of three edges counting acceptance.
    out_ready = 1'b1;
    send(8'd255, 8'd255, 1'b1);
    check("lat_edge1", out_valid, 0);
    tick();
    check("lat_edge2", out_valid, 0);
    tick();
    check("single_valid", out_valid, 1);
    check("single_out", out, 65025);
    check("single_cnt", out_cnt, 1);
    check("single_ovf", out_ovf, 0);
    tick();
    check("single_drop", out_valid, 0);

    // Three-element dot product, single-cycle valid pulse.
    send(8'd2, 8'd3, 1'b0);
    send(8'd4, 8'd5, 1'b0);
    send(8'd10, 8'd10, 1'b1);
    tick();
    tick();
    check("dot3_valid", out_valid, 1);
    check("dot3_out", out, 126);
    check("dot3_cnt", out_cnt, 3);
    check("dot3_ovf", out_ovf, 0);
    check("dot3_out16", out16, 126);
    tick();
    check("dot3_pulse", out_valid, 0);

    // Backpressure: 1x1 held while 2x2 stalls in stage B.
    out_ready = 1'b0;
    send(8'd1, 8'd1, 1'b1);
    send(8'd2, 8'd2, 1'b1);
    tick();
    check("bp_valid", out_valid, 1);
    check("bp_out", out, 1);
    check("bp_in_ready", in_ready, 0);
    tick();
    check("bp_hold_out", out, 1);
    check("bp_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    tick();
    check("bp_next_valid", out_valid, 1);
    check("bp_next_out", out, 4);
    check("bp_next_cnt", out_cnt, 1);
    tick();
    check("bp_empty", out_valid, 0);

    // Wrap in the 16-bit accumulator; the next vector starts with ovf clear.
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    tick();
    tick();
    check("wrap16_out", out16, 64514);
    check("wrap16_cnt", out_cnt16, 2);
    check("wrap16_ovf", out_ovf16, 1);
    check("wrap24_out", out, 130050);
    check("wrap24_ovf", out_ovf, 0);
    send(8'd1, 8'd1, 1'b1);
    tick();
    tick();
    check("after_wrap16_out", out16, 1);
    check("after_wrap16_ovf", out_ovf16, 0);

    // Zero-valued vector is still a result.
    send(8'd0, 8'd77, 1'b1);
    tick();
    tick();
    check("zero_valid", out_valid, 1);
    check("zero_out", out, 0);
    check("zero_cnt", out_cnt, 1);

    // Reset mid-vector discards the partial sum.
    send(8'd9, 8'd9, 1'b0);
    send(8'd9, 8'd9, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_out", out, 0);
    check("midrst_cnt", out_cnt, 0);
    check("midrst_valid", out_valid, 0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    send(8'd7, 8'd7, 1'b1);
    tick();
    tick();
    check("midrst_fresh_out", out, 49);
    check("midrst_fresh_cnt", out_cnt, 1);
    check("midrst_fresh_valid", out_valid, 1);
    tick();

    // Random vectors with gaps and backpressure against a scoreboard.
    fork
      begin : driver
        for (int v = 0; v < 12; v++) begin
          int    len;
          longint s;
          exp_t  e;
          len = (v == 1) ? 300 : $urandom_range(1, 30);
          s = 0;
          for (int k = 0; k < len; k++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            s += longint'(a) * longint'(b);
            if (k == len - 1) begin
              e.o24   = 24'(s);
              e.ovf24 = (s >= 64'd16777216);
              e.o16   = 16'(s);
              e.ovf16 = (s >= 64'd65536);
              e.cnt   = (len > 255) ? 8'd255 : 8'(len);
              exp_q.push_back(e);
            end
            if ($urandom_range(0, 3) == 0) tick();
            send(a, b, k == len - 1);
          end
        end
        drv_done = 1;
      end
      begin : ready_gen
        while (!mon_done) begin
          tick();
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
      begin : monitor
        int cyc = 0;
        while (!(drv_done && exp_q.size() == 0) && cyc < 50000) begin
          @(negedge clk);
          cyc++;
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("rand_unexpected", 1, 0);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              check("rand_out24", out, e.o24);
              check("rand_ovf24", out_ovf, e.ovf24);
              check("rand_out16", out16, e.o16);
              check("rand_ovf16", out_ovf16, e.ovf16);
              check("rand_cnt", out_cnt, e.cnt);
            end
          end
        end
        check("rand_drain", exp_q.size(), 0);
        mon_done = 1;
      end
    join
    out_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
